// File: rtl/md_issue_ctrl_pkg.sv
// md_issue_ctrl_pkg: mult/div mode codes, issue-controller state codes and op-class helpers.
package md_issue_ctrl_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_FDIV  = 4'd7;
    localparam logic [3:0] MD_BDS   = 4'd8;

    typedef enum logic [1:0] {
        MDCTRL_IDLE   = 2'd0,
        MDCTRL_ISSUED = 2'd1,
        MDCTRL_BUSY   = 2'd2
    } md_state_e;

    function automatic logic is_start(input logic [3:0] m);
        return m inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_FDIV, MD_BDS};
    endfunction

    function automatic logic is_move(input logic [3:0] m);
        return m inside {MD_MTHI, MD_MTLO};
    endfunction

endpackage

// File: rtl/md_issue_ctrl_lut.sv
// md_issue_ctrl_lut: maps a start-class mode to its busy latency minus one.
module md_issue_ctrl_lut
    import md_issue_ctrl_pkg::*;
#(
    parameter int LAT_MULT = 5,
    parameter int LAT_DIV  = 10,
    parameter int LAT_FDIV = 3
) (
    input  logic [3:0] mode_i,
    output logic [3:0] cnt_o
);

    always_comb begin
        cnt_o = (mode_i == MD_MULT || mode_i == MD_MULTU) ? 4'(LAT_MULT - 1) :
                (mode_i == MD_FDIV)                        ? 4'(LAT_FDIV - 1) :
                                                             4'(LAT_DIV - 1);
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage issue/stall controller for the HI/LO mult/div unit.
// Define MD_PERF_CNT_EN to add the perf_stall cycle counter output.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int LAT_MULT = 5,
    parameter int LAT_DIV  = 10,
    parameter int LAT_FDIV = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        e_valid,
    input  logic [3:0]  e_mode,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        e_hilo_rd,
    input  logic        e_hilo_sel,
    input  logic        md_busy,
    input  logic [31:0] md_out,
    output logic [3:0]  md_mode,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_hilosel,
    output logic        stall,
    output logic [31:0] e_rdata,
`ifdef MD_PERF_CNT_EN
    output logic [31:0] perf_stall,
`endif
    output logic        lat_err
);

    if (LAT_MULT < 1 || LAT_MULT > 15 || LAT_DIV < 1 || LAT_DIV > 15 ||
        LAT_FDIV < 1 || LAT_FDIV > 15) begin : g_lat_chk
        $error("md_issue_ctrl: LAT parameters must be in 1..15");
    end

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, lat_cnt;
    logic        exit_q, lat_err_q, lat_bad;
    logic        start_op, hazard, issue;

    md_issue_ctrl_lut #(
        .LAT_MULT (LAT_MULT),
        .LAT_DIV  (LAT_DIV),
        .LAT_FDIV (LAT_FDIV)
    ) u_lut (
        .mode_i (e_mode),
        .cnt_o  (lat_cnt)
    );

    assign start_op = is_start(e_mode);
    assign hazard   = e_valid & (start_op | is_move(e_mode) | e_hilo_rd) &
                      ((state_q != MDCTRL_IDLE) | md_busy);
    assign issue    = e_valid & ~hazard & ~Req;
    // Busy is only visible from the cycle after ISSUED, so an IDLE reached straight from ISSUED may still see it.
    assign lat_bad  = (state_q == MDCTRL_BUSY && cnt_q != 4'd0 && !md_busy) ||
                      (state_q == MDCTRL_IDLE && md_busy && !exit_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MDCTRL_IDLE;
            cnt_q     <= 4'd0;
            exit_q    <= 1'b0;
            lat_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exit_q    <= (state_q == MDCTRL_ISSUED);
            lat_err_q <= lat_err_q | lat_bad;
        end
    end

    // The shadow count runs in ISSUED too, so a LAT-cycle op stalls followers for exactly LAT cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == MDCTRL_IDLE) begin
            state_d = (issue & start_op) ? MDCTRL_ISSUED : MDCTRL_IDLE;
            cnt_d   = (issue & start_op) ? lat_cnt : cnt_q;
        end else begin
            state_d = (cnt_q == 4'd0) ? MDCTRL_IDLE : MDCTRL_BUSY;
            cnt_d   = cnt_q - 4'(cnt_q != 4'd0);
        end
    end

    always_comb begin
        stall      = hazard;
        md_mode    = issue ? e_mode : MD_NONE;
        md_a       = e_rs;
        md_b       = e_rt;
        md_hilosel = e_hilo_sel;
        e_rdata    = md_out;
        lat_err    = lat_err_q;
    end

`ifdef MD_PERF_CNT_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk) begin
        perf_q <= reset ? 32'd0 : perf_q + 32'(hazard);
    end
    assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed and random checks of md_issue_ctrl against a latency/HI-LO reference model.
module tb_md_issue_ctrl;
    import md_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset, Req, e_valid, e_hilo_rd, e_hilo_sel, md_busy;
    logic [3:0]  e_mode, md_mode;
    logic [31:0] e_rs, e_rt, md_out, md_a, md_b, e_rdata;
    logic        md_hilosel, stall, lat_err;

    md_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Req        (Req),
        .e_valid    (e_valid),
        .e_mode     (e_mode),
        .e_rs       (e_rs),
        .e_rt       (e_rt),
        .e_hilo_rd  (e_hilo_rd),
        .e_hilo_sel (e_hilo_sel),
        .md_busy    (md_busy),
        .md_out     (md_out),
        .md_mode    (md_mode),
        .md_a       (md_a),
        .md_b       (md_b),
        .md_hilosel (md_hilosel),
        .stall      (stall),
        .e_rdata    (e_rdata),
        .lat_err    (lat_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rem   = 0;
    int          cur_l = 0;
    logic [31:0] hi    = 32'd0;
    logic [31:0] lo    = 32'd0;
    logic        lat_exp   = 1'b0;
    logic        force_low = 1'b0;

    function automatic logic st_op(input logic [3:0] m);
        return m == MD_MULT || m == MD_MULTU || m == MD_DIV || m == MD_DIVU ||
               m == MD_FDIV || m == MD_BDS;
    endfunction

    function automatic logic mv_op(input logic [3:0] m);
        return m == MD_MTHI || m == MD_MTLO;
    endfunction

    function automatic int lat_of(input logic [3:0] m);
        return (m == MD_MULT || m == MD_MULTU) ? 5 : (m == MD_FDIV) ? 3 : 10;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m == MD_MULT) begin
            p  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (m == MD_MULTU) begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (m == MD_DIV && b != 0) begin
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end else if (m == MD_DIVU && b != 0) begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // One clock: drive at negedge, check before posedge, advance the model at posedge.
    task automatic cyc(input logic v, input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic rd, input logic sel, input logic rq,
                       output logic stl, output logic [31:0] rdat);
        logic cls, hz, iss;
        e_valid = v; e_mode = m; e_rs = a; e_rt = b;
        e_hilo_rd = rd; e_hilo_sel = sel; Req = rq;
        md_busy = !force_low && rem > 0 && rem < cur_l;
        md_out  = sel ? hi : lo;
        #1;
        cls = v && (st_op(m) || mv_op(m) || rd);
        hz  = cls && rem > 0;
        iss = v && !hz && !rq;
        chk1("stall", stall, hz);
        chk32("md_mode", 32'(md_mode), iss ? 32'(m) : 32'(MD_NONE));
        chk32("md_a", md_a, a);
        chk32("md_b", md_b, b);
        chk1("md_hilosel", md_hilosel, sel);
        chk32("e_rdata", e_rdata, sel ? hi : lo);
        chk1("lat_err", lat_err, lat_exp);
        stl  = hz;
        rdat = e_rdata;
        @(posedge clk);
        if (iss && st_op(m)) begin
            apply(m, a, b);
            rem   = lat_of(m);
            cur_l = rem;
        end else begin
            if (iss && m == MD_MTHI) hi = a;
            if (iss && m == MD_MTLO) lo = a;
            if (rem > 0) rem--;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic        s;
        logic [31:0] r;
        repeat (n) cyc(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, s, r);
    endtask

    // Holds an op in E until it issues; n returns the number of stalled cycles (bounded).
    task automatic issue_op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                            input logic rd, input logic sel, output int n, output logic [31:0] rdat);
        logic s;
        n = 0;
        cyc(1'b1, m, a, b, rd, sel, 1'b0, s, rdat);
        while (s && n < 60) begin
            n++;
            cyc(1'b1, m, a, b, rd, sel, 1'b0, s, rdat);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; e_valid = 1'b0; e_mode = MD_NONE; Req = 1'b0; md_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rem = 0; cur_l = 0; lat_exp = 1'b0;
    endtask

    initial begin
        int          n;
        logic        s;
        logic [31:0] r;
        logic [3:0]  m;
        logic        v, rd, sel, rq;
        logic [31:0] a, b;
        e_rs = 32'd0; e_rt = 32'd0; e_hilo_rd = 1'b0; e_hilo_sel = 1'b0; md_out = 32'd0;
        @(negedge clk);
        do_reset();
        idle(2);

        // MULT 3*-4 then mflo
        issue_op(MD_MULT, 32'd3, 32'hFFFF_FFFC, 1'b0, 1'b0, n, r);
        chk32("mult_issue_stalls", 32'(n), 32'd0);
        issue_op(MD_NONE, 32'd0, 32'd0, 1'b1, 1'b0, n, r);
        chk32("mflo_stalls", 32'(n), 32'd5);
        chk32("mflo_value", r, 32'hFFFF_FFF4);

        // DIV 7/2 then MTHI, then mfhi returns moved value
        issue_op(MD_DIV, 32'd7, 32'd2, 1'b0, 1'b0, n, r);
        issue_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b1, n, r);
        chk32("mthi_stalls", 32'(n), 32'd10);
        issue_op(MD_NONE, 32'd0, 32'd0, 1'b1, 1'b1, n, r);
        chk32("mfhi_stalls", 32'(n), 32'd0);
        chk32("mfhi_value", r, 32'h1234_5678);
        issue_op(MD_NONE, 32'd0, 32'd0, 1'b1, 1'b0, n, r);
        chk32("div_quot", r, 32'd3);

        // MULT with Req cancels, retry issues without stall
        cyc(1'b1, MD_MULT, 32'd6, 32'd7, 1'b0, 1'b0, 1'b1, s, r);
        chk1("req_no_stall", s, 1'b0);
        issue_op(MD_MULT, 32'd6, 32'd7, 1'b0, 1'b0, n, r);
        chk32("retry_stalls", 32'(n), 32'd0);
        issue_op(MD_NONE, 32'd0, 32'd0, 1'b1, 1'b0, n, r);
        chk32("retry_mflo", r, 32'd42);

        // FDIV then MULT back-to-back
        issue_op(MD_FDIV, 32'd9, 32'd3, 1'b0, 1'b0, n, r);
        issue_op(MD_MULTU, 32'd5, 32'd5, 1'b0, 1'b0, n, r);
        chk32("fdiv_mult_stalls", 32'(n), 32'd3);
        issue_op(MD_MULT, 32'd2, 32'd2, 1'b0, 1'b0, n, r);
        chk32("mult_after_mult", 32'(n), 32'd5);
        idle(6);

        // reset in the middle of a DIV
        issue_op(MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0, n, r);
        idle(3);
        do_reset();
        issue_op(MD_MULT, 32'd1, 32'd1, 1'b0, 1'b0, n, r);
        chk32("post_reset_stalls", 32'(n), 32'd0);
        idle(6);

        // Busy dropping early during BUSY latches lat_err until reset
        issue_op(MD_DIVU, 32'd50, 32'd5, 1'b0, 1'b0, n, r);
        idle(2);
        force_low = 1'b1;
        idle(1);
        force_low = 1'b0;
        lat_exp   = 1'b1;
        idle(12);
        chk1("lat_err_sticky", lat_err, 1'b1);
        do_reset();
        idle(1);

        for (int i = 0; i < 300; i++) begin
            m   = 4'($urandom_range(0, 8));
            v   = ($urandom_range(0, 3) != 0);
            rd  = (m == MD_NONE) && ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 1) == 1;
            rq  = ($urandom_range(0, 7) == 0);
            a   = $urandom;
            b   = $urandom;
            if (b == 32'd0) b = 32'd1;
            cyc(v, m, a, b, rd, sel, rq, s, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
